// File: rtl/fir_stream_ctrl_if.sv
// Sample-in / filtered-word-out stream bundle for fir_stream_ctrl.
// The slave modport is the controller's view. The master modport is the view of the surrounding environment.
interface fir_stream_ctrl_if #(
  parameter int DATA_WIDTH = 24
);
  // Handshake on both streams: a word moves on a rising edge where valid && ready are both high.
  // The source holds its data stable while valid is high and not yet taken.
  // o_s_ready never depends on i_s_valid.
  logic [DATA_WIDTH-1:0] iv_s_data;
  logic                  i_s_valid;
  logic                  o_s_ready;
  logic [DATA_WIDTH-1:0] ov_m_data;
  logic                  o_m_valid;
  logic                  i_m_ready;
  logic                  o_m_last;
  logic                  o_m_ovf;

  modport slave (
    input  iv_s_data, i_s_valid, i_m_ready,
    output o_s_ready, ov_m_data, o_m_valid, o_m_last, o_m_ovf
  );

  modport master (
    output iv_s_data, i_s_valid, i_m_ready,
    input  o_s_ready, ov_m_data, o_m_valid, o_m_last, o_m_ovf
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// Sequencer between a valid/ready sample stream and an enable-driven systolic FIR, with flush and priming tracking.
// Optional sticky per-tap overflow register: define FIR_STREAM_CTRL_OVF_STICKY_EN.
module fir_stream_ctrl #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIR_DEPTH   = 128,
  parameter int FIR_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fir_stream_ctrl_if.slave      s_if,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_primed,
  output logic                  o_fir_en,
  output logic [DATA_WIDTH-1:0] ov_fir_din,
  input  logic [DATA_WIDTH-1:0] iv_fir_dout,
  input  logic [FIR_DEPTH-1:0]  iv_prod_ovf,
  input  logic [FIR_DEPTH-1:0]  iv_sum_ovf,
`ifdef FIR_STREAM_CTRL_OVF_STICKY_EN
  input  logic                  i_ovf_clr,
  output logic [FIR_DEPTH-1:0]  ov_ovf_tap,
`endif
  output logic [1:0]            ov_dbg_state
);

  localparam int            CW       = $clog2(FIR_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIR_DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(FIR_DEPTH - 1);
  localparam logic [3:0]    LAT_C    = 4'(FIR_LATENCY);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_flush_pend;
  logic                  r_flushing;
  logic [CW-1:0]         r_flush_cnt;
  logic [CW-1:0]         r_fire_cnt;
  logic                  r_primed;
  logic [3:0]            r_lat_cnt;
  logic [DATA_WIDTH-1:0] r_fir_din;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic                  r_m_ovf;

  logic w_out_free;
  logic w_s_ready;
  logic w_accept;
  logic w_flush_start;
  logic w_flush_fire;
  logic w_capture;
  logic w_flush_done;

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_flush_start = 1'b0;
    w_flush_fire  = 1'b0;
    w_capture     = 1'b0;
    w_out_free    = !r_m_valid || s_if.i_m_ready;
    w_s_ready     = (r_state == ST_RUN) && !r_flush_pend && !r_flushing && w_out_free;
    // Flush fires also wait for a free output slot, so a stalled sink never loses a flush word.
    case (r_state)
      ST_RUN: begin
        if (s_if.i_s_valid && w_s_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FIRE;
        end else if (r_flush_pend && w_out_free) begin
          w_flush_start = 1'b1;
          w_state_nxt   = ST_FIRE;
        end else if (r_flushing && (r_flush_cnt != '0) && w_out_free) begin
          w_flush_fire = 1'b1;
          w_state_nxt  = ST_FIRE;
        end
      end
      ST_FIRE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (r_lat_cnt == 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    w_flush_done = w_capture && r_flushing && (r_flush_cnt == CW'(1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_RUN;
      r_flush_pend <= 1'b0;
      r_flushing   <= 1'b0;
      r_flush_cnt  <= '0;
      r_fire_cnt   <= '0;
      r_primed     <= 1'b0;
      r_lat_cnt    <= '0;
      r_fir_din    <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_m_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_fir_din <= s_if.iv_s_data;
      end else if (w_flush_start || w_flush_fire) begin
        r_fir_din <= '0;
      end

      // A flush request arriving while one is pending or running is dropped.
      if (w_flush_start) begin
        r_flush_pend <= 1'b0;
      end else if (i_flush && !r_flushing) begin
        r_flush_pend <= 1'b1;
      end

      if (w_flush_start) begin
        r_flushing <= 1'b1;
      end else if (w_flush_done) begin
        r_flushing <= 1'b0;
      end

      if (w_flush_start) begin
        r_flush_cnt <= DEPTH_C;
      end else if (w_capture && r_flushing) begin
        r_flush_cnt <= r_flush_cnt - CW'(1);
      end

      if (w_flush_done) begin
        r_fire_cnt <= '0;
        r_primed   <= 1'b0;
      end else if (r_state == ST_FIRE) begin
        if (r_fire_cnt != DEPTH_C) begin
          r_fire_cnt <= r_fire_cnt + CW'(1);
        end
        if (r_fire_cnt >= DEPTH_M1) begin
          r_primed <= 1'b1;
        end
      end

      if (r_state == ST_FIRE) begin
        r_lat_cnt <= LAT_C;
      end else if (r_state == ST_WAIT) begin
        r_lat_cnt <= r_lat_cnt - 4'd1;
      end

      if (w_capture) begin
        r_m_data  <= iv_fir_dout;
        r_m_ovf   <= (|iv_prod_ovf) || (|iv_sum_ovf);
        r_m_valid <= 1'b1;
        r_m_last  <= w_flush_done;
      end else if (r_m_valid && s_if.i_m_ready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

`ifdef FIR_STREAM_CTRL_OVF_STICKY_EN
  logic [FIR_DEPTH-1:0] r_ovf_tap;
  logic [FIR_DEPTH-1:0] w_ovf_set;

  assign w_ovf_set = w_capture ? (iv_prod_ovf | iv_sum_ovf) : '0;

  // Set is OR-ed after the clear so a same-cycle set survives.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf_tap <= '0;
    end else begin
      r_ovf_tap <= (i_ovf_clr ? '0 : r_ovf_tap) | w_ovf_set;
    end
  end

  assign ov_ovf_tap = r_ovf_tap;
`endif

  assign s_if.o_s_ready = w_s_ready;
  assign s_if.ov_m_data = r_m_data;
  assign s_if.o_m_valid = r_m_valid;
  assign s_if.o_m_last  = r_m_last;
  assign s_if.o_m_ovf   = r_m_ovf;
  assign o_fir_en       = (r_state == ST_FIRE);
  assign ov_fir_din     = r_fir_din;
  assign o_primed       = r_primed;
  assign o_busy         = (r_state != ST_RUN) || r_flush_pend;
  assign ov_dbg_state   = r_state;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench for fir_stream_ctrl with a stand-in filter whose output is valid only one cycle after each enable.
// Covers the FIR_STREAM_CTRL_OVF_STICKY_EN build when that macro is defined.
module tb_fir_stream_ctrl;
  localparam int DW    = 24;
  localparam int DEPTH = 128;
  localparam int LAT   = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              busy;
  logic              primed;
  logic              fir_en;
  logic [DW-1:0]     fir_din;
  logic [DW-1:0]     fir_dout;
  logic [DEPTH-1:0]  prod_ovf;
  logic [DEPTH-1:0]  sum_ovf;
  logic [1:0]        dbg_state;
`ifdef FIR_STREAM_CTRL_OVF_STICKY_EN
  logic              ovf_clr;
  logic [DEPTH-1:0]  ovf_tap;
`endif

  always #5 clk = ~clk;

  fir_stream_ctrl_if #(.DATA_WIDTH(DW)) s_if ();

  fir_stream_ctrl #(
    .DATA_WIDTH (DW),
    .FIR_DEPTH  (DEPTH),
    .FIR_LATENCY(LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .s_if        (s_if.slave),
    .i_flush     (flush),
    .o_busy      (busy),
    .o_primed    (primed),
    .o_fir_en    (fir_en),
    .ov_fir_din  (fir_din),
    .iv_fir_dout (fir_dout),
    .iv_prod_ovf (prod_ovf),
    .iv_sum_ovf  (sum_ovf),
`ifdef FIR_STREAM_CTRL_OVF_STICKY_EN
    .i_ovf_clr   (ovf_clr),
    .ov_ovf_tap  (ovf_tap),
`endif
    .ov_dbg_state(dbg_state)
  );

  // Stand-in filter: dout = ~din for exactly one cycle after the enable, garbage and all-ones prod_ovf otherwise.
  logic          f_en_d;
  logic [DW-1:0] f_din_d;
  logic          f_ovf_d;
  logic          ovf_q[$];
  bit            f_pop;

  always @(posedge clk) begin
    if (rst) begin
      f_en_d  <= 1'b0;
      f_din_d <= '0;
      f_ovf_d <= 1'b0;
    end else begin
      f_en_d <= fir_en;
      if (fir_en) begin
        f_pop = 1'b0;
        if (ovf_q.size() > 0) f_pop = ovf_q.pop_front();
        f_din_d <= fir_din;
        f_ovf_d <= f_pop;
      end
    end
  end

  assign fir_dout = f_en_d ? ~f_din_d : 24'hBAD0BA;
  assign prod_ovf = f_en_d ? '0 : '1;
  always_comb begin
    sum_ovf    = '0;
    sum_ovf[5] = f_en_d && f_ovf_d;
  end

  // Scoreboard: {ovf, last, data}
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] cur_exp;
  logic          cur_ovf;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            en_cnt  = 0;
  int            out_cnt = 0;
  bit            chk_flush_din = 1'b0;
  bit            last_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (s_if.i_s_valid && s_if.o_s_ready) begin
        exp_q.push_back(cur_exp);
        ovf_q.push_back(cur_ovf);
      end
      if (fir_en) begin
        en_cnt++;
        if (chk_flush_din) check("flush_din_zero", fir_din, 0);
      end
      if (s_if.o_m_valid && s_if.i_m_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_unexpected: got %0h expected none", s_if.ov_m_data);
        end else begin
          check("out_word", {s_if.o_m_ovf, s_if.o_m_last, s_if.ov_m_data}, exp_q.pop_front());
          if (s_if.o_m_last) last_seen = 1'b1;
        end
      end
    end
  end

  bit rnd_mode = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) s_if.i_m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_if.i_s_valid = 1'b0;
    flush = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    ovf_q.delete();
    rst = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic ovf, input logic [DW-1:0] exp_d, input logic exp_ovf);
    bit ok = 1'b0;
    s_if.iv_s_data = d;
    s_if.i_s_valid = 1'b1;
    cur_ovf        = ovf;
    cur_exp        = {exp_ovf, 1'b0, exp_d};
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = s_if.o_s_ready;
      tick();
    end
    s_if.i_s_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      if (exp_q.size() == 0 && !s_if.o_m_valid && !busy) break;
      tick();
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic          ovf;
    logic [DW-1:0] exp_d;
    logic          exp_ovf;
  } vec_t;
  vec_t tv[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [DW-1:0] d;

    tv[0] = '{24'h000000, 1'b0, 24'hFFFFFF, 1'b0};
    tv[1] = '{24'h7FFFFF, 1'b0, 24'h800000, 1'b0};
    tv[2] = '{24'h800000, 1'b0, 24'h7FFFFF, 1'b0};
    tv[3] = '{24'h123456, 1'b1, 24'hEDCBA9, 1'b1};
    tv[4] = '{24'hFFFFFF, 1'b0, 24'h000000, 1'b0};
    tv[5] = '{24'hA5A5A5, 1'b0, 24'h5A5A5A, 1'b0};
    tv[6] = '{24'h000001, 1'b0, 24'hFFFFFE, 1'b0};

    s_if.iv_s_data = '0;
    s_if.i_m_ready = 1'b1;
    cur_exp = '0;
    cur_ovf = 1'b0;
`ifdef FIR_STREAM_CTRL_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    do_reset();

    // Reset values
    @(negedge clk);
    check("rst_m_valid", s_if.o_m_valid, 0);
    check("rst_m_data", s_if.ov_m_data, 0);
    check("rst_m_last", s_if.o_m_last, 0);
    check("rst_m_ovf", s_if.o_m_ovf, 0);
    check("rst_fir_en", fir_en, 0);
    check("rst_fir_din", fir_din, 0);
    check("rst_primed", primed, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_if.o_s_ready, 1);
    check("rst_state", dbg_state, 0);

    // Single sample cycle-by-cycle
    tick();
    cur_exp = {1'b0, 1'b0, 24'hFFFEFF};
    cur_ovf = 1'b0;
    s_if.iv_s_data = 24'h000100;
    s_if.i_s_valid = 1'b1;
    @(negedge clk);
    check("t0_s_ready", s_if.o_s_ready, 1);
    tick();
    s_if.i_s_valid = 1'b0;
    @(negedge clk);
    check("t1_fir_en", fir_en, 1);
    check("t1_s_ready", s_if.o_s_ready, 0);
    check("t1_fir_din", fir_din, 24'h000100);
    @(negedge clk);
    check("t2_fir_en", fir_en, 0);
    check("t2_s_ready", s_if.o_s_ready, 0);
    check("t2_m_valid", s_if.o_m_valid, 0);
    @(negedge clk);
    check("t3_m_valid", s_if.o_m_valid, 1);
    check("t3_m_data", s_if.ov_m_data, 24'hFFFEFF);
    tick();
    wait_idle();

    // Table vectors, including one overflow word
    for (int i = 0; i < 7; i++) send(tv[i].din, tv[i].ovf, tv[i].exp_d, tv[i].exp_ovf);
    wait_idle();
`ifdef FIR_STREAM_CTRL_OVF_STICKY_EN
    @(negedge clk);
    check("sticky_set", ovf_tap, {{(DEPTH-6){1'b0}}, 6'b100000});
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("sticky_clr", ovf_tap, 0);
`endif

    // Backpressure
    s_if.i_m_ready = 1'b0;
    base = out_cnt;
    send(24'h00ABCD, 1'b0, 24'hFF5432, 1'b0);
    for (int k = 0; k < 50 && !s_if.o_m_valid; k++) tick();
    cur_exp = {1'b0, 1'b0, 24'hEDCBA9};
    cur_ovf = 1'b0;
    s_if.iv_s_data = 24'h123456;
    s_if.i_s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_s_ready_low", s_if.o_s_ready, 0);
      tick();
    end
    s_if.i_m_ready = 1'b1;
    @(negedge clk);
    check("bp_s_ready_rise", s_if.o_s_ready, 1);
    tick();
    s_if.i_s_valid = 1'b0;
    rnd_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = DW'($urandom);
      send(d, 1'b0, ~d, 1'b0);
    end
    rnd_mode = 1'b0;
    s_if.i_m_ready = 1'b1;
    wait_idle();
    check("bp_out_count", out_cnt - base, 12);

    // Priming
    do_reset();
    en_cnt = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      d = DW'($urandom);
      send(d, 1'b0, ~d, 1'b0);
    end
    d = DW'($urandom);
    send(d, 1'b0, ~d, 1'b0);
    @(negedge clk);
    check("prime_last_en", fir_en, 1);
    check("prime_before", primed, 0);
    @(negedge clk);
    check("prime_after", primed, 1);
    wait_idle();
    check("prime_en_count", en_cnt, DEPTH);

    // Flush colliding with an accepted sample
    en_cnt = 0;
    last_seen = 1'b0;
    base = out_cnt;
    tick();
    cur_exp = {1'b0, 1'b0, 24'hFEDCBA};
    cur_ovf = 1'b0;
    s_if.iv_s_data = 24'h012345;
    s_if.i_s_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("fl_accept_ready", s_if.o_s_ready, 1);
    tick();
    s_if.i_s_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({1'b0, (i == DEPTH - 1), 24'hFFFFFF});
    @(negedge clk);
    tick();
    chk_flush_din = 1'b1;
    @(negedge clk);
    check("fl_busy", busy, 1);
    for (int k = 0; k < 2000 && !last_seen; k++) tick();
    chk_flush_din = 1'b0;
    check("fl_last_seen", last_seen, 1);
    repeat (3) tick();
    @(negedge clk);
    check("fl_primed_clear", primed, 0);
    check("fl_en_count", en_cnt, DEPTH + 1);
    check("fl_out_count", out_cnt - base, DEPTH + 1);
    check("fl_busy_end", busy, 0);

    // Reset in WAIT with 60 flush words remaining
    base = out_cnt;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({1'b0, (i == DEPTH - 1), 24'hFFFFFF});
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if ((out_cnt - base) >= 68 && dbg_state == 2'd1) break;
      tick();
    end
    check("rf_reached", out_cnt - base, 68);
    tick();
    check("rf_in_wait", dbg_state, 2);
    rst = 1'b1;
    exp_q.delete();
    ovf_q.delete();
    tick();
    rst = 1'b0;
    en_cnt = 0;
    @(negedge clk);
    check("rf_m_valid", s_if.o_m_valid, 0);
    check("rf_m_data", s_if.ov_m_data, 0);
    check("rf_m_last", s_if.o_m_last, 0);
    check("rf_fir_en", fir_en, 0);
    check("rf_fir_din", fir_din, 0);
    check("rf_s_ready", s_if.o_s_ready, 1);
    check("rf_primed", primed, 0);
    check("rf_busy", busy, 0);
    repeat (10) tick();
    check("rf_no_fire", en_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
